cache_refill_ctrl: RTL and testbench

- Control FSM for the set-associative read cache datapath (word/tag/valid arrays plus tag compare).
- Sequences the CPU lookup and the miss refill of a whole line from memory, one word per memory handshake.
- Selects the victim way per set by round-robin and writes tag/valid on fill completion.
- Flushes all valid bits after reset; the datapath supplies the hit result, this block drives every array write.

---
 rtl/cache_pkg.sv | 44 ++++
 rtl/cache_victim_ptr.sv | 33 +++
 rtl/cache_refill_ctrl.sv | 144 ++++++++++++++
 tb/tb_cache_refill_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types, widths and address helpers for the
// set-associative read cache refill controller.
package cache_pkg;

  localparam int LINE_SIZE   = 32;
  localparam int ASSOC       = 2;
  localparam int INDEX_DEPTH = 4;
  localparam int OFFSET_SIZE = 2;
  localparam int TAG_SIZE    =
    LINE_SIZE - INDEX_DEPTH - OFFSET_SIZE - 2;

  localparam int NUM_WAYS  = 1 << ASSOC;
  localparam int NUM_SETS  = 1 << INDEX_DEPTH;
  localparam int NUM_WORDS = 1 << OFFSET_SIZE;

  typedef logic [LINE_SIZE-1:0]   word_t;
  typedef logic [TAG_SIZE-1:0]    tag_t;
  typedef logic [INDEX_DEPTH-1:0] index_t;
  typedef logic [OFFSET_SIZE-1:0] offset_t;
  typedef logic [ASSOC-1:0]       way_t;

  typedef enum logic [2:0] {
    FLUSH,
    IDLE,
    LOOKUP,
    REFILL,
    UPDATE
  } state_e;

  function automatic index_t addr_index(word_t a);
    return a[2+OFFSET_SIZE +: INDEX_DEPTH];
  endfunction

  function automatic tag_t addr_tag(word_t a);
    return a[LINE_SIZE-1 -: TAG_SIZE];
  endfunction

  function automatic word_t word_addr(
    tag_t t, index_t i, offset_t o
  );
    return {t, i, o, 2'b00};
  endfunction

endpackage

// File: rtl/cache_victim_ptr.sv
// Per-set round-robin victim way counters.
// Advancing bumps only the counter of the selected set.
module cache_victim_ptr
  import cache_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  index_t index,
  input  logic   advance,
  output way_t   victim
);

  way_t ptr_q [NUM_SETS];
  way_t ptr_d [NUM_SETS];

  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d[index] = way_t'(ptr_q[index] + 1'b1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '{default: '0};
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign victim = ptr_q[index];

endmodule

// File: rtl/cache_refill_ctrl.sv
// Lookup/refill sequencer for the read cache: flushes valid
// bits, fills a whole line on miss, installs tag/valid.
module cache_refill_ctrl
  import cache_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cpu_read,
  input  logic [LINE_SIZE-1:0]   address,
  output logic                   busywait,
  input  logic                   hit,
  output logic [INDEX_DEPTH-1:0] arr_index,
  output logic [ASSOC-1:0]       arr_way,
  output logic [OFFSET_SIZE-1:0] arr_offset,
  output logic                   arr_we,
  output logic [LINE_SIZE-1:0]   arr_wdata,
  output logic                   tag_we,
  output logic                   valid_we,
  output logic                   valid_wdata,
  output logic                   valid_clr,
  output logic                   mem_read,
  output logic [LINE_SIZE-1:0]   mem_address,
  input  logic [LINE_SIZE-1:0]   mem_readdata,
  input  logic                   mem_busywait
);

  state_e  state_q, state_d;
  index_t  flush_cnt_q, flush_cnt_d;
  offset_t word_cnt_q, word_cnt_d;
  way_t    victim_q, victim_d;
  way_t    victim;
  logic    advance;
  index_t  cur_index;
  tag_t    cur_tag;

  assign cur_index = addr_index(address);
  assign cur_tag   = addr_tag(address);

  cache_victim_ptr u_victim (
    .clk     (clk),
    .reset   (reset),
    .index   (cur_index),
    .advance (advance),
    .victim  (victim)
  );

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    word_cnt_d  = word_cnt_q;
    victim_d    = victim_q;
    arr_index   = cur_index;
    arr_way     = '0;
    arr_offset  = '0;
    arr_we      = 1'b0;
    arr_wdata   = '0;
    tag_we      = 1'b0;
    valid_we    = 1'b0;
    valid_wdata = 1'b0;
    valid_clr   = 1'b0;
    mem_read    = 1'b0;
    mem_address = '0;
    advance     = 1'b0;

    unique case (state_q)
      FLUSH: begin
        valid_clr   = 1'b1;
        arr_index   = flush_cnt_q;
        flush_cnt_d = index_t'(flush_cnt_q + 1'b1);
        if (flush_cnt_q == index_t'(NUM_SETS - 1)) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (cpu_read) begin
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit) begin
          state_d = IDLE;
        end else begin
          victim_d   = victim;
          word_cnt_d = '0;
          state_d    = REFILL;
        end
      end
      REFILL: begin
        mem_read    = 1'b1;
        mem_address =
          word_addr(cur_tag, cur_index, word_cnt_q);
        if (!mem_busywait) begin
          arr_we     = 1'b1;
          arr_way    = victim_q;
          arr_offset = word_cnt_q;
          arr_wdata  = mem_readdata;
          word_cnt_d = offset_t'(word_cnt_q + 1'b1);
          if (word_cnt_q == offset_t'(NUM_WORDS - 1)) begin
            state_d = UPDATE;
          end
        end
      end
      UPDATE: begin
        tag_we      = 1'b1;
        valid_we    = 1'b1;
        valid_wdata = 1'b1;
        arr_way     = victim_q;
        advance     = 1'b1;
        state_d     = LOOKUP;
      end
      default: begin
        state_d = FLUSH;
      end
    endcase

    // Reset kills array/memory activity in the same cycle.
    if (reset) begin
      arr_we    = 1'b0;
      tag_we    = 1'b0;
      valid_we  = 1'b0;
      valid_clr = 1'b0;
      mem_read  = 1'b0;
      advance   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FLUSH;
      flush_cnt_q <= '0;
      word_cnt_q  <= '0;
      victim_q    <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      word_cnt_q  <= word_cnt_d;
      victim_q    <= victim_d;
    end
  end

  assign busywait = (state_q == FLUSH) |
    (cpu_read & ~((state_q == LOOKUP) & hit));

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl with tag/valid array
// and latency-programmable memory models.
module tb_cache_refill_ctrl;

  logic        clk;
  logic        reset;
  logic        cpu_read;
  logic [31:0] address;
  logic        busywait;
  logic        hit;
  logic [3:0]  arr_index;
  logic [1:0]  arr_way;
  logic [1:0]  arr_offset;
  logic        arr_we;
  logic [31:0] arr_wdata;
  logic        tag_we;
  logic        valid_we;
  logic        valid_wdata;
  logic        valid_clr;
  logic        mem_read;
  logic [31:0] mem_address;
  logic [31:0] mem_readdata;
  logic        mem_busywait;

  cache_refill_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_read     (cpu_read),
    .address      (address),
    .busywait     (busywait),
    .hit          (hit),
    .arr_index    (arr_index),
    .arr_way      (arr_way),
    .arr_offset   (arr_offset),
    .arr_we       (arr_we),
    .arr_wdata    (arr_wdata),
    .tag_we       (tag_we),
    .valid_we     (valid_we),
    .valid_wdata  (valid_wdata),
    .valid_clr    (valid_clr),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_readdata (mem_readdata),
    .mem_busywait (mem_busywait)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] DMASK = 32'hA5A5_5A5A;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // tag/valid array model producing the hit input
  logic        mv [16][4];
  logic [23:0] mt [16][4];

  always @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < 16; s++)
        for (int w = 0; w < 4; w++) mv[s][w] <= 1'b0;
    end else begin
      if (valid_clr)
        for (int w = 0; w < 4; w++) mv[arr_index][w] <= 1'b0;
      if (valid_we) mv[arr_index][arr_way] <= valid_wdata;
      if (tag_we) mt[arr_index][arr_way] <= address[31:8];
    end
  end

  always_comb begin
    hit = 1'b0;
    for (int w = 0; w < 4; w++)
      if (mv[address[7:4]][w] === 1'b1 &&
          mt[address[7:4]][w] == address[31:8])
        hit = 1'b1;
  end

  // memory: mem_lat stall cycles before each word
  int mem_lat = 0;
  int lat_cnt = 0;

  assign mem_busywait = mem_read && (lat_cnt < mem_lat);
  assign mem_readdata = mem_address ^ DMASK;

  always @(posedge clk) begin
    if (mem_read && mem_busywait) lat_cnt <= lat_cnt + 1;
    else lat_cnt <= 0;
  end

  // activity monitor
  int n_rd = 0, n_acc = 0, n_we = 0;
  int n_tag = 0, n_excl = 0;
  logic [31:0] acc_log [256];
  logic [1:0]  way_log [256];
  logic [1:0]  off_log [256];
  logic [31:0] dat_log [256];
  logic [1:0]  tway_log [256];

  always @(posedge clk) begin
    if (mem_read) n_rd <= n_rd + 1;
    if (mem_read && !mem_busywait) begin
      acc_log[n_acc[7:0]] <= mem_address;
      n_acc <= n_acc + 1;
    end
    if (arr_we) begin
      way_log[n_we[7:0]] <= arr_way;
      off_log[n_we[7:0]] <= arr_offset;
      dat_log[n_we[7:0]] <= arr_wdata;
      n_we <= n_we + 1;
    end
    if (tag_we) begin
      tway_log[n_tag[7:0]] <= arr_way;
      n_tag <= n_tag + 1;
    end
    if ((int'(arr_we) + int'(tag_we) + int'(valid_clr)) > 1 ||
        tag_we != valid_we)
      n_excl <= n_excl + 1;
  end

  int b_rd, b_acc, b_we, b_tag;

  task automatic snap;
    b_rd = n_rd; b_acc = n_acc;
    b_we = n_we; b_tag = n_tag;
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic wait_ready(output int c);
    logic busy;
    c = 0;
    busy = 1'b1;
    while (busy && c < 100) begin
      @(negedge clk);
      c++;
      busy = busywait;
      if (busy) tick();
    end
    if (busy) chk("ready_timeout", 32'(busy), 0);
    tick();
    cpu_read = 1'b0;
  endtask

  task automatic access(input logic [31:0] a,
                        output int c);
    tick();
    cpu_read = 1'b1;
    address  = a;
    wait_ready(c);
  endtask

  task automatic do_reset;
    reset    = 1'b1;
    cpu_read = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    repeat (16) tick();
  endtask

  task automatic check_fill(input logic [31:0] base,
                            input logic [1:0] way);
    logic [31:0] wa;
    for (int k = 0; k < 4; k++) begin
      wa = base + 32'(4 * k);
      chk("fill_addr", acc_log[(b_acc + k) % 256], wa);
      chk("fill_way", 32'(way_log[(b_we + k) % 256]),
          32'(way));
      chk("fill_off", 32'(off_log[(b_we + k) % 256]),
          32'(k));
      chk("fill_data", dat_log[(b_we + k) % 256],
          wa ^ DMASK);
    end
    chk("fill_tag_cnt", 32'(n_tag - b_tag), 1);
    chk("fill_tag_way", 32'(tway_log[b_tag % 256]),
        32'(way));
  endtask

  int cyc;

  initial begin
    reset    = 1'b1;
    cpu_read = 1'b1;
    address  = 32'h0000_0040;
    mem_lat  = 0;
    snap();
    tick();
    @(negedge clk);
    chk("rst_mem_read", 32'(mem_read), 0);
    chk("rst_arr_we", 32'(arr_we), 0);
    chk("rst_tag_we", 32'(tag_we), 0);
    chk("rst_busy", 32'(busywait), 1);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("flush_clr", 32'(valid_clr), 1);
      chk("flush_idx", 32'(arr_index), 32'(i));
      chk("flush_busy", 32'(busywait), 1);
      tick();
    end
    wait_ready(cyc);
    chk("miss0_cycles", 32'(cyc), 8);
    chk("miss0_rd_cycles", 32'(n_rd - b_rd), 4);
    check_fill(32'h0000_0040, 2'd0);

    do_reset();
    mem_lat = 3;
    snap();
    access(32'h1000_0040, cyc);
    chk("cold_cycles", 32'(cyc), 20);
    chk("cold_rd_cycles", 32'(n_rd - b_rd), 16);
    check_fill(32'h1000_0040, 2'd0);

    snap();
    access(32'h1000_0040, cyc);
    chk("hit_cycles", 32'(cyc), 2);
    chk("hit_no_rd", 32'(n_rd - b_rd), 0);
    chk("hit_no_we", 32'(n_we - b_we), 0);

    do_reset();
    mem_lat = 0;
    for (int t = 1; t <= 5; t++) begin
      snap();
      access(32'(t << 8) | 32'h40, cyc);
      chk("rr_cycles", 32'(cyc), 8);
      chk("rr_way", 32'(tway_log[b_tag % 256]),
          32'((t - 1) % 4));
    end
    snap();
    access(32'h0000_0340, cyc);
    chk("rr_hit3", 32'(cyc), 2);
    snap();
    access(32'h0000_0150, cyc);
    check_fill(32'h0000_0150, 2'd0);
    snap();
    access(32'h0000_0140, cyc);
    chk("rr_evict_cycles", 32'(cyc), 8);
    check_fill(32'h0000_0140, 2'd1);

    snap();
    tick();
    cpu_read = 1'b1;
    address  = 32'h1000_00C0;
    repeat (4) tick();
    cpu_read = 1'b0;
    repeat (5) tick();
    @(negedge clk);
    chk("drop_busy", 32'(busywait), 0);
    chk("drop_we_cnt", 32'(n_we - b_we), 4);
    check_fill(32'h1000_00C0, 2'd0);
    snap();
    access(32'h1000_00C0, cyc);
    chk("drop_hit", 32'(cyc), 2);

    snap();
    tick();
    cpu_read = 1'b1;
    address  = 32'h1000_0080;
    repeat (4) tick();
    reset    = 1'b1;
    cpu_read = 1'b0;
    @(negedge clk);
    chk("abort_rd_now", 32'(mem_read), 0);
    chk("abort_we_now", 32'(arr_we), 0);
    tick();
    @(negedge clk);
    chk("abort_rd_next", 32'(mem_read), 0);
    chk("abort_we_next", 32'(arr_we), 0);
    chk("abort_busy", 32'(busywait), 1);
    chk("abort_words", 32'(n_we - b_we), 2);
    chk("abort_no_tag", 32'(n_tag - b_tag), 0);
    do_reset();
    snap();
    access(32'h1000_0080, cyc);
    chk("abort_remiss", 32'(cyc), 8);
    chk("abort_rd_cycles", 32'(n_rd - b_rd), 4);
    check_fill(32'h1000_0080, 2'd0);

    chk("strobe_excl", 32'(n_excl), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
